macc_csd_frame: RTL and testbench
=================================

// Module: macc_csd_frame
// PURPOSE
//  Parametrised constant-coefficient multiply-accumulate. The multiplier is a shift-add
//  (CSD) network, so no DSP multiplier is used. Samples accumulate in frames of ACC_LEN,
//  with optional saturation and a run-time single-bit error-injection port.
//  It is the generalised successor of the fixed x29 shift-add MAC used in the
//  error-insertion experiments.
// PARAMETERS
//  SIZEIN   16         input sample width, signed
//  SIZEOUT  40         accumulator/output width, signed; must be >= PW (checked at elaboration)
//  NTERMS   3          number of CSD terms, 1..8
//  SHIFTS   {8'd5,8'd2,8'd0}  packed 8-bit shift per term, term i = SHIFTS[8i+:8]
//  SIGNS    3'b010     per-term sign, 1 = subtract; the defaults give coefficient +1-4+32 = 29
//  ACC_LEN  16         valid samples per frame, >= 1
//  SATURATE 1          1 = clamp on overflow, 0 = two's-complement wrap
//  Derived: PW = SIZEIN + max(SHIFTS) + 1 (product width); CW = $clog2(ACC_LEN+1)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  ce         in   1          clock enable; when low, the pipeline holds
//  in_valid   in   1          'a' carries a sample this cycle
//  sload      in   1          this sample starts a new frame (with in_valid)
//  a          in   SIZEIN     signed sample
//  inj_en     in   1          error-injection enable
//  inj_bit    in   $clog2(SIZEOUT)  bit index to flip
//  accum_out  out  SIZEOUT    signed running or final accumulation
//  out_valid  out  1          one-cycle pulse: frame complete, accum_out is the frame result
//  ovf        out  1          sticky overflow within the current frame
// BEHAVIOUR
//  Reset: all pipeline registers, accum_out, out_valid, ovf and the frame counter are 0,
//   taking effect immediately. Release takes effect on the next clk edge.
//  Pipeline (advances only when ce=1):
//   S1: a_r<=a, v1<=in_valid, s1<=sload.
//   S2: prod<=sum of +/-(sext(a_r,PW)<<SHIFTS[i]), computed in PW bits; v2<=v1; s2<=s1.
//   S3: accumulator update when v2=1.
//  Latency: a sample presented at edge k appears in accum_out after edge k+3 (ce held high).
//  Frame start: occurs when s2=1, or on the first v2 after a frame completes or after reset.
//   On a frame start, acc<=sext(prod) (the old value is discarded), cnt<=1 and ovf<=0.
//  Otherwise, on v2=1: sum = acc+sext(prod) computed in SIZEOUT+1 bits, and cnt<=cnt+1.
//   If the sum is outside the SIZEOUT range, ovf<=1 and:
//    SATURATE=1: acc is clamped to 2^(SIZEOUT-1)-1 or -2^(SIZEOUT-1).
//    SATURATE=0: acc takes the low SIZEOUT bits.
//  Injection: if inj_en=1 on an S3 update and inj_bit<SIZEOUT, bit inj_bit of the stored
//   value is inverted (after saturation), and this is fed back into later sums.
//   It applies on every update while inj_en is high. An inj_bit >= SIZEOUT is ignored.
//  Completion: when an update makes cnt==ACC_LEN, out_valid<=1 for that cycle only.
//   The next v2 then starts a new frame. accum_out holds its value until the next update.
//  sload mid-frame: that sample starts a new frame. The partial frame is dropped and
//   produces no out_valid.
//  out_valid is a registered pulse. It is forced to 0 on any edge where ce=0 or no
//   completing update occurs. All other state holds while ce=0.
//  in_valid=0 with ce=1: bubbles flow through, and acc, cnt and ovf do not change.
//  sload with in_valid=0: ignored (it is qualified by the valid bit).
//  ACC_LEN=1: every valid sample is its own frame, and out_valid pulses per sample.
// TESTING
//  1) Defaults with ACC_LEN=4: a=1 on 4 consecutive cycles with sload on the first ->
//     accum_out 29,58,87,116, with out_valid=1 only with 116, 3 cycles after the 4th sample.
//  2) a=-2 with sload, then a=3 -> accum_out -58, then 29; ovf=0.
//  3) SIZEOUT=22, ACC_LEN=4, a=32767 x4 -> 950243, 1900486, then 2097151 (ovf=1) twice.
//     Repeat with SATURATE=0 -> the third value wraps to -1343575 and ovf=1.
//  4) Injection: a=1 with sload, inj_en=1 and inj_bit=0 at the S3 update -> accum_out=28.
//     inj_bit=SIZEOUT -> accum_out=29.
//  5) Drop ce for 2 cycles and insert in_valid=0 bubbles mid-frame -> results identical
//     to case 1, shifted in time; out_valid is never high while ce=0.
//  6) sload after 2 samples, then rst_n low mid-frame -> the first frame gives no pulse.
//     During reset, all outputs are 0 immediately, and the next sample starts a fresh frame.

Source files
------------

// File: rtl/macc_csd_frame.sv
// Constant-coefficient MAC built from a CSD shift-add network. Samples are summed in frames
// of ACC_LEN, with optional saturation and a run-time single-bit error-injection port.
module macc_csd_frame #(
    parameter int unsigned          SIZEIN   = 16,
    parameter int unsigned          SIZEOUT  = 40,
    parameter int unsigned          NTERMS   = 3,
    parameter logic [8*NTERMS-1:0]  SHIFTS   = {8'd5, 8'd2, 8'd0},
    parameter logic [NTERMS-1:0]    SIGNS    = 3'b010,
    parameter int unsigned          ACC_LEN  = 16,
    parameter bit                   SATURATE = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic                        sload,
    input  logic signed [SIZEIN-1:0]    a,
    input  logic                        inj_en,
    input  logic [$clog2(SIZEOUT)-1:0]  inj_bit,
    output logic signed [SIZEOUT-1:0]   accum_out,
    output logic                        out_valid,
    output logic                        ovf
);

    function automatic int unsigned max_shift(input logic [63:0] sh, input int unsigned n);
        int unsigned m;
        m = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n && 32'(sh[8*i +: 8]) > m) m = 32'(sh[8*i +: 8]);
        end
        return m;
    endfunction

    localparam int unsigned PW = SIZEIN + max_shift(64'(SHIFTS), NTERMS) + 1;
    localparam int unsigned SW = SIZEOUT + 1;
    localparam int unsigned CW = $clog2(ACC_LEN + 1);
    localparam logic [SIZEOUT-1:0] ACC_MAX = {1'b0, {(SIZEOUT-1){1'b1}}};
    localparam logic [SIZEOUT-1:0] ACC_MIN = {1'b1, {(SIZEOUT-1){1'b0}}};

    if (SIZEOUT < PW) begin : g_bad_width
        $error("macc_csd_frame: SIZEOUT must be >= product width");
    end
    if (NTERMS < 1 || NTERMS > 8) begin : g_bad_nterms
        $error("macc_csd_frame: NTERMS must be 1..8");
    end
    if (ACC_LEN < 1) begin : g_bad_len
        $error("macc_csd_frame: ACC_LEN must be >= 1");
    end

    logic signed [SIZEIN-1:0]  a_r;
    logic                      v1, s1, v2, s2;
    logic signed [PW-1:0]      prod;
    logic [CW-1:0]             cnt;

    logic signed [PW-1:0]      prod_c;
    logic signed [PW-1:0]      term_c;
    logic                      start_c;
    logic signed [SIZEOUT-1:0] base_c;
    logic signed [SW-1:0]      sum_c;
    logic                      over_c;
    logic [SIZEOUT-1:0]        acc_nxt_c;
    logic                      ovf_nxt_c;
    logic [CW-1:0]             cnt_nxt_c;
    logic                      done_c;

    // Shift-add product of the registered sample
    always_comb begin
        prod_c = '0;
        term_c = '0;
        for (int unsigned i = 0; i < NTERMS; i++) begin
            term_c = PW'(a_r) <<< SHIFTS[8*i +: 8];
            if (SIGNS[i]) prod_c = prod_c - term_c;
            else          prod_c = prod_c + term_c;
        end
    end

    // A frame starts on sload, after a completed frame, or on the first sample after reset
    always_comb begin
        start_c   = s2 || (cnt == '0) || (cnt == CW'(ACC_LEN));
        base_c    = start_c ? '0 : accum_out;
        sum_c     = SW'(base_c) + SW'(prod);
        over_c    = sum_c[SW-1] ^ sum_c[SW-2];
        if (over_c && SATURATE) acc_nxt_c = sum_c[SW-1] ? ACC_MIN : ACC_MAX;
        else                    acc_nxt_c = sum_c[SIZEOUT-1:0];
        // A shift past the MSB yields a zero mask, so out-of-range indices flip nothing
        acc_nxt_c = acc_nxt_c ^ (SIZEOUT'(inj_en) << inj_bit);
        ovf_nxt_c = (start_c ? 1'b0 : ovf) | over_c;
        cnt_nxt_c = start_c ? CW'(1) : cnt + CW'(1);
        done_c    = (cnt_nxt_c == CW'(ACC_LEN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= '0;
            v1        <= 1'b0;
            s1        <= 1'b0;
            prod      <= '0;
            v2        <= 1'b0;
            s2        <= 1'b0;
            cnt       <= '0;
            accum_out <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (ce) begin
            a_r       <= a;
            v1        <= in_valid;
            s1        <= sload;
            prod      <= prod_c;
            v2        <= v1;
            s2        <= s1;
            out_valid <= v2 && done_c;
            if (v2) begin
                accum_out <= acc_nxt_c;
                cnt       <= cnt_nxt_c;
                ovf       <= ovf_nxt_c;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_macc_csd_frame.sv
// Directed bench for macc_csd_frame: default coefficient 29 with ACC_LEN 4 and 1,
// plus a 22-bit accumulator in saturating and wrapping forms.
module tb_macc_csd_frame;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ce = 1'b0;
    logic               in_valid = 1'b0;
    logic               sload = 1'b0;
    logic signed [15:0] a = '0;
    logic               inj_en = 1'b0;
    logic [5:0]         inj_bit = '0;

    logic signed [39:0] acc0, acc3;
    logic signed [21:0] acc1, acc2;
    logic               ov0, ov1, ov2, ov3;
    logic               ovf0, ovf1, ovf2, ovf3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    macc_csd_frame #(.ACC_LEN(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .sload(sload), .a(a),
        .inj_en(inj_en), .inj_bit(inj_bit), .accum_out(acc0), .out_valid(ov0), .ovf(ovf0));

    macc_csd_frame #(.SIZEOUT(22), .ACC_LEN(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .sload(sload), .a(a),
        .inj_en(inj_en), .inj_bit(inj_bit[4:0]), .accum_out(acc1), .out_valid(ov1), .ovf(ovf1));

    macc_csd_frame #(.SIZEOUT(22), .ACC_LEN(4), .SATURATE(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .sload(sload), .a(a),
        .inj_en(inj_en), .inj_bit(inj_bit[4:0]), .accum_out(acc2), .out_valid(ov2), .ovf(ovf2));

    macc_csd_frame #(.ACC_LEN(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .sload(sload), .a(a),
        .inj_en(inj_en), .inj_bit(inj_bit), .accum_out(acc3), .out_valid(ov3), .ovf(ovf3));

    typedef struct {
        logic   ce, iv, sl;
        int     a;
        logic   chk;
        longint acc;
        logic   ov;
        logic   chk3;
        longint acc3;
        logic   ov3;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input int c, input int iv, input int sl, input int av,
                                input int ck, input longint ac, input int o,
                                input int c3, input longint a3, input int o3);
        vec_t v;
        v.ce = c[0]; v.iv = iv[0]; v.sl = sl[0]; v.a = av;
        v.chk = ck[0]; v.acc = ac; v.ov = o[0];
        v.chk3 = c3[0]; v.acc3 = a3; v.ov3 = o3[0];
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input int iv, input int sl, input int av,
                         input int ie, input int ib);
        ce = c[0]; in_valid = iv[0]; sload = sl[0]; a = 16'(av);
        inj_en = ie[0]; inj_bit = 6'(ib);
    endtask

    initial begin
        //               ce iv sl  a  chk  acc  ov  c3  acc3 ov3
        tbl[0]  = mk(1, 1, 1,  1, 0,   0, 0, 0,   0, 0);
        tbl[1]  = mk(1, 1, 0,  1, 0,   0, 0, 0,   0, 0);
        tbl[2]  = mk(1, 1, 0,  1, 1,  29, 0, 1,  29, 1);
        tbl[3]  = mk(1, 1, 0,  1, 1,  58, 0, 1,  29, 1);
        tbl[4]  = mk(1, 0, 0,  0, 1,  87, 0, 1,  29, 1);
        tbl[5]  = mk(1, 0, 0,  0, 1, 116, 1, 1,  29, 1);
        tbl[6]  = mk(1, 0, 0,  0, 1, 116, 0, 1,  29, 0);
        tbl[7]  = mk(1, 0, 0,  0, 0,   0, 0, 0,   0, 0);
        tbl[8]  = mk(1, 1, 1, -2, 0,   0, 0, 0,   0, 0);
        tbl[9]  = mk(1, 1, 0,  3, 0,   0, 0, 0,   0, 0);
        tbl[10] = mk(1, 0, 0,  0, 1, -58, 0, 1, -58, 1);
        tbl[11] = mk(1, 0, 0,  0, 1,  29, 0, 1,  87, 1);
        tbl[12] = mk(1, 0, 0,  0, 1,  29, 0, 1,  87, 0);
        tbl[13] = mk(1, 1, 1,  1, 0,   0, 0, 0,   0, 0);
        tbl[14] = mk(0, 0, 0,  0, 1,  29, 0, 1,  87, 0);
        tbl[15] = mk(0, 0, 0,  0, 1,  29, 0, 0,   0, 0);
        tbl[16] = mk(1, 1, 0,  1, 1,  29, 0, 0,   0, 0);
        tbl[17] = mk(1, 0, 0,  0, 1,  29, 0, 1,  29, 1);
        tbl[18] = mk(1, 1, 0,  1, 1,  58, 0, 1,  29, 1);
        tbl[19] = mk(1, 1, 0,  1, 1,  58, 0, 1,  29, 0);
        tbl[20] = mk(1, 0, 0,  0, 1,  87, 0, 0,   0, 0);
        tbl[21] = mk(1, 0, 0,  0, 1, 116, 1, 0,   0, 0);
        tbl[22] = mk(1, 0, 0,  0, 1, 116, 0, 0,   0, 0);

        // Reset state
        #12;
        check("reset acc", longint'(acc0), 0);
        check("reset out_valid", longint'(ov0), 0);
        check("reset ovf", longint'(ovf0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Frames, bubbles and clock-enable gaps
        for (int i = 0; i < 23; i++) begin
            drive(int'(tbl[i].ce), int'(tbl[i].iv), int'(tbl[i].sl), tbl[i].a, 0, 0);
            step();
            if (tbl[i].chk) begin
                check($sformatf("row%0d acc", i), longint'(acc0), tbl[i].acc);
                check($sformatf("row%0d out_valid", i), longint'(ov0), longint'(tbl[i].ov));
                check($sformatf("row%0d ovf", i), longint'(ovf0), 0);
            end
            if (tbl[i].chk3) begin
                check($sformatf("row%0d len1 acc", i), longint'(acc3), tbl[i].acc3);
                check($sformatf("row%0d len1 out_valid", i), longint'(ov3), longint'(tbl[i].ov3));
                check($sformatf("row%0d len1 ovf", i), longint'(ovf3), 0);
            end
        end

        // Overflow in a 22-bit accumulator: saturate vs wrap
        drive(1, 1, 1, 32767, 0, 0); step();
        drive(1, 1, 0, 32767, 0, 0); step();
        drive(1, 1, 0, 32767, 0, 0); step();
        check("sat first", longint'(acc1), 950243);
        check("wrap first", longint'(acc2), 950243);
        drive(1, 1, 0, 32767, 0, 0); step();
        check("sat second", longint'(acc1), 1900486);
        check("sat second ovf", longint'(ovf1), 0);
        drive(1, 0, 0, 0, 0, 0); step();
        check("sat third", longint'(acc1), 2097151);
        check("sat third ovf", longint'(ovf1), 1);
        check("wrap third", longint'(acc2), -1343575);
        check("wrap third ovf", longint'(ovf2), 1);
        step();
        check("sat fourth", longint'(acc1), 2097151);
        check("sat fourth out_valid", longint'(ov1), 1);
        check("sat fourth ovf", longint'(ovf1), 1);
        check("wrap fourth", longint'(acc2), -393332);
        check("wrap fourth out_valid", longint'(ov2), 1);

        // Injection at bit 0, fed back into the next sum
        drive(1, 1, 1, 1, 0, 0); step();
        drive(1, 1, 0, 1, 0, 0); step();
        drive(1, 0, 0, 0, 1, 0); step();
        check("inj bit0", longint'(acc0), 28);
        drive(1, 0, 0, 0, 0, 0); step();
        check("inj feedback", longint'(acc0), 57);
        // Out-of-range index is ignored
        drive(1, 1, 1, 1, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 1, 40); step();
        check("inj out of range", longint'(acc0), 29);
        drive(1, 0, 0, 0, 0, 0); step();

        // sload mid-frame drops the partial frame, then reset mid-frame
        drive(1, 1, 1, 1, 0, 0); step();
        drive(1, 1, 0, 1, 0, 0); step();
        drive(1, 1, 1, 1, 0, 0); step();
        check("drop s1", longint'(acc0), 29);
        drive(1, 1, 0, 1, 0, 0); step();
        check("drop s2", longint'(acc0), 58);
        drive(1, 0, 0, 0, 0, 0); step();
        check("restart s1", longint'(acc0), 29);
        check("restart s1 out_valid", longint'(ov0), 0);
        step();
        check("restart s2", longint'(acc0), 58);
        check("restart s2 out_valid", longint'(ov0), 0);
        drive(1, 1, 0, 7, 0, 0); step();
        #2 rst_n = 1'b0;
        #1;
        check("mid reset acc", longint'(acc0), 0);
        check("mid reset out_valid", longint'(ov0), 0);
        check("mid reset ovf", longint'(ovf0), 0);
        check("mid reset acc sat", longint'(acc1), 0);
        drive(1, 0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, (i < 4) ? 1 : 0, 0, (i < 4) ? 1 : 0, 0, 0);
            step();
            if (i >= 2) begin
                check($sformatf("post reset %0d acc", i), longint'(acc0), longint'(29 * (i - 1)));
                check($sformatf("post reset %0d out_valid", i), longint'(ov0), (i == 5) ? 1 : 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
